// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter for the 8:1 16-bit datapath bus mux.
// Grants one requester at a time and can force rotation after MAX_HOLD cycles.
module bus_arbiter_8 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] select,
    output logic       bus_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    // With no hold limit the counter just parks at all-ones.
    localparam logic [CNT_W-1:0] CNT_SAT  = (MAX_HOLD == 0) ? '1 : HOLD_LIM;

    state_t           state;
    logic [2:0]       last_owner;
    logic [CNT_W-1:0] cnt;

    logic [7:0] owner_mask;
    logic [7:0] others;
    logic [7:0] cand;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       found;
    logic       force_rotate;

    assign owner_mask   = 8'b1 << last_owner;
    assign others       = req & ~owner_mask;
    // While granting, the owner is never its own successor.
    assign cand         = (state == GRANT) ? others : req;
    assign force_rotate = (MAX_HOLD != 0) && (cnt == HOLD_LIM) && (|others);

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        winner = last_owner;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = last_owner + 3'(k);
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            select     <= '0;
            bus_valid  <= 1'b0;
            preempt    <= 1'b0;
            cnt        <= '0;
            last_owner <= 3'd7;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant      <= 8'b1 << winner;
                        select     <= winner;
                        bus_valid  <= 1'b1;
                        last_owner <= winner;
                        cnt        <= CNT_W'(1);
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[last_owner]) begin
                        if (|others) begin
                            grant      <= 8'b1 << winner;
                            select     <= winner;
                            last_owner <= winner;
                            cnt        <= CNT_W'(1);
                        end else begin
                            grant     <= '0;
                            bus_valid <= 1'b0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end
                    end else if (force_rotate) begin
                        grant      <= 8'b1 << winner;
                        select     <= winner;
                        last_owner <= winner;
                        cnt        <= CNT_W'(1);
                        preempt    <= 1'b1;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed self-checking bench for bus_arbiter_8 with MAX_HOLD=4.
module tb_bus_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] select;
    logic       bus_valid;
    logic       preempt;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter_8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .select    (select),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;

        // 1: reset state, idle, then single request
        tick();
        check("rst_grant", grant, 8'h00);
        check("rst_select", select, 3'd0);
        check("rst_valid", bus_valid, 1'b0);
        check("rst_preempt", preempt, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("idle_grant", grant, 8'h00);
        check("idle_valid", bus_valid, 1'b0);
        check("idle_select", select, 3'd0);
        req = 8'h10;
        tick();
        check("t1_grant", grant, 8'h10);
        check("t1_select", select, 3'd4);
        check("t1_valid", bus_valid, 1'b1);

        // 2: direct handover without bubble, then release to idle
        do_reset();
        req = 8'h05;
        tick();
        check("t2_grant0", grant, 8'h01);
        check("t2_select0", select, 3'd0);
        req = 8'h04;
        tick();
        check("t2_grant2", grant, 8'h04);
        check("t2_select2", select, 3'd2);
        check("t2_valid2", bus_valid, 1'b1);
        req = 8'h00;
        tick();
        check("t2_grant_idle", grant, 8'h00);
        check("t2_valid_idle", bus_valid, 1'b0);
        check("t2_select_hold", select, 3'd2);

        // 3: hold limit rotates between two requesters
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t3_hold0", grant, 8'h01);
            check("t3_pre0", preempt, 1'b0);
        end
        tick();
        check("t3_rot1", grant, 8'h02);
        check("t3_rot1_pre", preempt, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t3_hold1", grant, 8'h02);
            check("t3_pre1", preempt, 1'b0);
        end
        tick();
        check("t3_rot0", grant, 8'h01);
        check("t3_rot0_pre", preempt, 1'b1);

        // 4: lone requester is never preempted
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t4_grant", grant, 8'h08);
            check("t4_pre", preempt, 1'b0);
        end

        // 5: wrap-around after owner 7, via handover and via idle
        do_reset();
        req = 8'h80;
        tick();
        check("t5_own7", grant, 8'h80);
        req = 8'h01;
        tick();
        check("t5_wrap_grant", grant, 8'h01);
        check("t5_wrap_select", select, 3'd0);
        do_reset();
        req = 8'h80;
        tick();
        req = 8'h00;
        tick();
        check("t5_idle_select", select, 3'd7);
        req = 8'h81;
        tick();
        check("t5_idle_wrap", grant, 8'h01);
        check("t5_idle_wrap_sel", select, 3'd0);

        // 7: all sources requesting rotate 0..7,0 with 4-cycle tenures
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check("t7_grant", grant, 32'(1) << (k % 8));
                check("t7_select", select, 32'(k % 8));
                check("t7_pre", preempt, (c == 0 && k > 0) ? 1'b1 : 1'b0);
            end
        end

        // 6: asynchronous reset mid-grant
        do_reset();
        req = 8'h20;
        tick();
        check("t6_grant", grant, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", grant, 8'h00);
        check("t6_async_valid", bus_valid, 1'b0);
        check("t6_async_pre", preempt, 1'b0);
        req = 8'hFF;
        tick();
        check("t6_held_grant", grant, 8'h00);
        rst_n = 1'b1;
        tick();
        check("t6_first_grant", grant, 8'h01);
        check("t6_first_select", select, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
